// File: rtl/rx_frame_ctrl.sv
// rx_frame_ctrl: receive sequencer between the PHY byte stream and the port ingress FIFO.
// Hunts preamble/SFD, drives the shared CRC-32 unit, forwards frame bytes and grades each frame.
module rx_frame_ctrl #(
  parameter int          DATA_WIDTH     = 8,
  parameter int          MIN_PREAMBLE   = 7,
  parameter int          MIN_FRAME_SIZE = 64,
  parameter int          MAX_FRAME_SIZE = 1518,
  parameter logic [31:0] CRC_RESIDUE    = 32'hC704DD7B,
  parameter int          CNT_W          = $clog2(MAX_FRAME_SIZE + 2)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_valid,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_end,
  output logic                  crc_clear,
  output logic                  crc_en,
  input  logic [31:0]           crc_residue,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_sof,
  output logic                  out_eof,
  output logic                  frame_done,
  output logic                  frame_ok,
  output logic                  err_crc,
  output logic                  err_runt,
  output logic                  err_giant,
  output logic [CNT_W-1:0]      byte_count
);

  typedef enum logic [2:0] {IDLE, PREAMBLE, FRAME, CHECK, DROP} state_t;

  localparam logic [DATA_WIDTH-1:0] PRE_BYTE = DATA_WIDTH'(8'h55);
  localparam logic [DATA_WIDTH-1:0] SFD_BYTE = DATA_WIDTH'(8'hD5);
  localparam logic [CNT_W-1:0]      CNT_MAX  = CNT_W'(MAX_FRAME_SIZE);
  localparam logic [CNT_W-1:0]      CNT_SAT  = CNT_W'(MAX_FRAME_SIZE + 1);
  localparam logic [CNT_W-1:0]      CNT_MIN  = CNT_W'(MIN_FRAME_SIZE);
  localparam logic [3:0]            PRE_SAT  = 4'd15;
  localparam logic [3:0]            PRE_MIN  = 4'(MIN_PREAMBLE);

  state_t           state, state_next;
  logic [3:0]       pre_cnt;
  logic [CNT_W-1:0] cnt;
  logic             giant;

  logic is_pre, sfd_ok, frame_byte, fwd, in_check, runt, crc_bad;

  assign is_pre     = rx_valid && (rx_data == PRE_BYTE);
  assign sfd_ok     = (state == PREAMBLE) && rx_valid && !rx_end &&
                      (rx_data == SFD_BYTE) && (pre_cnt >= PRE_MIN);
  assign frame_byte = (state == FRAME) && rx_valid;
  assign fwd        = frame_byte && (cnt < CNT_MAX);
  assign in_check   = (state == CHECK);
  assign runt       = cnt < CNT_MIN;
  assign crc_bad    = crc_residue != CRC_RESIDUE;

  assign crc_clear = sfd_ok;
  assign crc_en    = fwd;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (is_pre) state_next = PREAMBLE;
      PREAMBLE: begin
        if (rx_end)        state_next = IDLE;
        else if (sfd_ok)   state_next = FRAME;
        else if (rx_valid && !is_pre) state_next = DROP;
      end
      FRAME:    if (rx_end) state_next = CHECK;
      CHECK:    state_next = IDLE;
      DROP:     if (rx_end) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_cnt <= '0;
      cnt     <= '0;
      giant   <= 1'b0;
    end else begin
      if (state == IDLE && is_pre)
        pre_cnt <= 4'd1;
      else if (state == PREAMBLE && is_pre && pre_cnt != PRE_SAT)
        pre_cnt <= pre_cnt + 4'd1;
      if (sfd_ok) begin
        cnt   <= '0;
        giant <= 1'b0;
      end else if (frame_byte) begin
        if (cnt != CNT_SAT) cnt <= cnt + 1'b1;
        if (!fwd)           giant <= 1'b1;
      end
    end
  end

  // Forwarded bytes appear one cycle after they arrive; oversize tail bytes are swallowed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sof   <= 1'b0;
      out_eof   <= 1'b0;
    end else begin
      out_valid <= fwd;
      out_data  <= rx_data;
      out_sof   <= fwd && (cnt == '0);
      out_eof   <= fwd && rx_end;
    end
  end

  // Grade with priority giant > runt > crc; status bits are only nonzero alongside frame_done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_done <= 1'b0;
      frame_ok   <= 1'b0;
      err_crc    <= 1'b0;
      err_runt   <= 1'b0;
      err_giant  <= 1'b0;
      byte_count <= '0;
    end else begin
      frame_done <= in_check;
      err_giant  <= in_check && giant;
      err_runt   <= in_check && !giant && runt;
      err_crc    <= in_check && !giant && !runt && crc_bad;
      frame_ok   <= in_check && !giant && !runt && !crc_bad;
      if (in_check) byte_count <= cnt;
    end
  end

endmodule

// File: tb/tb_rx_frame_ctrl.sv
// tb_rx_frame_ctrl: randomized frames against a frame-level reference model, with an
// environment CRC-32 unit driven by the DUT's crc_clear/crc_en.
module tb_rx_frame_ctrl;

  localparam int MIN_FRAME = 64;
  localparam int MAX_FRAME = 1518;

  logic        clock, reset;
  logic        rxValid, rxEnd;
  logic [7:0]  rxData;
  logic        crcClear, crcEn;
  logic [31:0] crcResidue;
  logic        outValid, outSof, outEof;
  logic [7:0]  outData;
  logic        frameDone, frameOk, errCrc, errRunt, errGiant;
  logic [10:0] byteCount;

  rx_frame_ctrl dut (
    .clk(clock), .rst(reset),
    .rx_valid(rxValid), .rx_data(rxData), .rx_end(rxEnd),
    .crc_clear(crcClear), .crc_en(crcEn), .crc_residue(crcResidue),
    .out_valid(outValid), .out_data(outData), .out_sof(outSof), .out_eof(outEof),
    .frame_done(frameDone), .frame_ok(frameOk), .err_crc(errCrc),
    .err_runt(errRunt), .err_giant(errGiant), .byte_count(byteCount)
  );

  typedef struct { logic [7:0] data; bit sof; bit eof; int cyc; } expByte_t;
  typedef struct { bit ok; bit crc; bit runt; bit giant; int count; int cyc; } expStat_t;

  expByte_t    expBytes[$];
  expStat_t    expStats[$];
  int          testsRun = 0;
  int          failCount = 0;
  int          cycle = 0;
  int          crcEnCount = 0;
  int          crcClearCount = 0;
  int          lastCount = 0;
  logic [31:0] crcReg = 32'h0;

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cycle <= cycle + 1;

  function automatic logic [31:0] crcStep(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  function automatic logic [31:0] bitRev32(input logic [31:0] v);
    logic [31:0] r;
    for (int k = 0; k < 32; k++) r[k] = v[31-k];
    return r;
  endfunction

  // Shared CRC unit as seen by the port: reflected engine, residue presented MSB-first.
  always @(posedge clock) begin
    if (crcClear)   crcReg <= 32'hFFFFFFFF;
    else if (crcEn) crcReg <= crcStep(crcReg, rxData);
  end
  assign crcResidue = bitRev32(crcReg);

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    testsRun++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cycle);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [7:0] d, input logic e);
    rxValid = v;
    rxData  = d;
    rxEnd   = e;
    @(posedge clock);
    #1;
  endtask

  task automatic maybeGap(input int gapPct);
    if ($urandom_range(0, 99) < gapPct) applyStimulus(1'b0, 8'($urandom), 1'b0);
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      if (crcEn)    crcEnCount++;
      if (crcClear) crcClearCount++;
      if (outValid) begin
        checkOutput("byte_pending", 64'(expBytes.size() != 0), 1);
        if (expBytes.size() != 0) begin
          expByte_t e;
          e = expBytes.pop_front();
          checkOutput("out_data", outData, e.data);
          checkOutput("out_sof", outSof, e.sof);
          checkOutput("out_eof", outEof, e.eof);
          checkOutput("byte_latency", cycle, e.cyc);
        end
      end else if (outSof || outEof) checkOutput("sof_eof_idle", {outSof, outEof}, 0);
      if (frameDone) begin
        checkOutput("status_pending", 64'(expStats.size() != 0), 1);
        if (expStats.size() != 0) begin
          expStat_t s;
          s = expStats.pop_front();
          checkOutput("frame_ok", frameOk, s.ok);
          checkOutput("err_crc", errCrc, s.crc);
          checkOutput("err_runt", errRunt, s.runt);
          checkOutput("err_giant", errGiant, s.giant);
          checkOutput("byte_count", byteCount, s.count);
          checkOutput("done_latency", cycle, s.cyc);
        end
      end else if (frameOk || errCrc || errRunt || errGiant)
        checkOutput("status_idle", {frameOk, errCrc, errRunt, errGiant}, 0);
    end
  end

  task automatic sendFrame(input int pre, input logic [7:0] sfd, input int n, input int corrupt,
                           input bit endSep, input int gapPct, input int abortAt);
    logic [7:0]  body[$];
    logic [31:0] c;
    bit          accept, fcsOk, giant, runt, last;
    expStat_t    st;
    crcEnCount    = 0;
    crcClearCount = 0;
    for (int i = 0; i < n - 4; i++) body.push_back(8'($urandom));
    if (n >= 4) begin
      c = 32'hFFFFFFFF;
      for (int i = 0; i < n - 4; i++) c = crcStep(c, body[i]);
      c = ~c;
      for (int k = 0; k < 4; k++) body.push_back(c[8*k +: 8]);
    end else
      for (int i = 0; i < n; i++) body.push_back(8'($urandom));
    if (corrupt >= 0 && corrupt < n) body[corrupt] = body[corrupt] ^ (8'h1 << $urandom_range(0, 7));

    // Frame-level grading: an FCS field equal to the complemented CRC of the rest is good.
    fcsOk = 1'b0;
    if (n >= 4) begin
      c = 32'hFFFFFFFF;
      for (int i = 0; i < n - 4; i++) c = crcStep(c, body[i]);
      fcsOk = (~c == {body[n-1], body[n-2], body[n-3], body[n-4]});
    end
    accept   = (pre >= 7) && (sfd == 8'hD5);
    giant    = n > MAX_FRAME;
    runt     = !giant && (n < MIN_FRAME);
    st.ok    = !giant && !runt && fcsOk;
    st.crc   = !giant && !runt && !fcsOk;
    st.runt  = runt;
    st.giant = giant;
    st.count = giant ? MAX_FRAME + 1 : n;

    for (int i = 0; i < pre; i++) begin
      maybeGap(gapPct);
      applyStimulus(1'b1, 8'h55, 1'b0);
    end
    maybeGap(gapPct);
    applyStimulus(1'b1, sfd, 1'b0);
    for (int i = 0; i < n; i++) begin
      if (i == abortAt) begin
        reset   = 1'b1;
        rxValid = 1'b0;
        rxEnd   = 1'b0;
        #1;
        checkOutput("abort_out_valid", outValid, 0);
        checkOutput("abort_frame_done", frameDone, 0);
        checkOutput("abort_sof_eof", {outSof, outEof}, 0);
        checkOutput("abort_byte_count", byteCount, 0);
        checkOutput("abort_crc_en", crcEn, 0);
        expBytes.delete();
        expStats.delete();
        lastCount = 0;
        @(posedge clock);
        #1;
        reset = 1'b0;
        repeat (4) applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("abort_no_status", expStats.size() + expBytes.size(), 0);
        return;
      end
      maybeGap(gapPct);
      last = (i == n - 1) && !endSep;
      if (accept && i < MAX_FRAME) expBytes.push_back('{body[i], i == 0, last, cycle + 1});
      if (accept && last) begin
        st.cyc = cycle + 2;
        expStats.push_back(st);
      end
      applyStimulus(1'b1, body[i], last);
    end
    if (endSep) begin
      maybeGap(gapPct);
      if (accept) begin
        st.cyc = cycle + 2;
        expStats.push_back(st);
      end
      applyStimulus(1'b0, 8'($urandom), 1'b1);
    end
    repeat (4) applyStimulus(1'b0, 8'($urandom), 1'b0);
    if (accept) lastCount = st.count;
    checkOutput("bytes_drained", expBytes.size(), 0);
    checkOutput("status_drained", expStats.size(), 0);
    checkOutput("crc_en_count", crcEnCount, accept ? ((n < MAX_FRAME) ? n : MAX_FRAME) : 0);
    checkOutput("crc_clear_count", crcClearCount, accept ? 1 : 0);
    checkOutput("byte_count_hold", byteCount, lastCount);
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got running, expected finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset   = 1'b1;
    rxValid = 1'b0;
    rxData  = 8'h00;
    rxEnd   = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    checkOutput("reset_out_valid", outValid, 0);
    checkOutput("reset_frame_done", frameDone, 0);
    checkOutput("reset_status", {frameOk, errCrc, errRunt, errGiant}, 0);
    checkOutput("reset_byte_count", byteCount, 0);
    checkOutput("reset_crc_ctrl", {crcClear, crcEn}, 0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    repeat (2) applyStimulus(1'b0, 8'h00, 1'b1);

    sendFrame(7, 8'hD5, 64, -1, 0, 0, -1);
    sendFrame(7, 8'hD5, 64, 10, 0, 0, -1);
    sendFrame(7, 8'hD5, 60, -1, 0, 0, -1);
    sendFrame(7, 8'hD5, 1520, -1, 0, 0, -1);
    sendFrame(5, 8'hD5, 64, -1, 0, 0, -1);
    sendFrame(7, 8'hD5, 64, -1, 0, 0, -1);
    sendFrame(8, 8'hD5, 80, -1, 0, 0, 30);
    sendFrame(7, 8'hD5, 64, -1, 0, 0, -1);
    sendFrame(7, 8'hD5, 63, -1, 0, 0, -1);
    sendFrame(7, 8'hD5, 1518, -1, 1, 0, -1);
    sendFrame(7, 8'hD5, 1519, -1, 0, 0, -1);
    sendFrame(20, 8'hD5, 70, -1, 1, 20, -1);
    sendFrame(9, 8'h5D, 70, -1, 0, 0, -1);
    sendFrame(6, 8'hD5, 64, -1, 0, 0, -1);
    sendFrame(7, 8'hD5, 2, -1, 0, 0, -1);

    for (int f = 0; f < 25; f++) begin
      int n, pre, corrupt;
      logic [7:0] sfd;
      n       = ($urandom_range(0, 9) < 7) ? $urandom_range(1, 80) : $urandom_range(1510, 1525);
      pre     = $urandom_range(4, 16);
      sfd     = ($urandom_range(0, 9) == 0) ? 8'h5D : 8'hD5;
      corrupt = ($urandom_range(0, 2) == 0) ? $urandom_range(0, n - 1) : -1;
      sendFrame(pre, sfd, n, corrupt, 1'($urandom_range(0, 1)), $urandom_range(0, 30), -1);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
